ets_alert_servicer: RTL and testbench
=====================================

# ets_alert_servicer

Register-bus initiator that owns the ETS monitor's memory-mapped register port. It drives the monitor's `reg_wr_en`/`reg_addr`/`reg_wr_data` inputs and consumes `reg_rd_data` and `alert_interrupt`. After reset it writes the control and alert-config registers once. On every rising edge of `alert_interrupt` it reads the last-anomaly PC, timing delta and anomaly count, and queues them as a record in a small FIFO for a downstream logger or DMA.

## Interface
- `DEPTH`, 4: record FIFO depth (power of two, ≥2).
- `CTRL_INIT`, 32'h0000_0001: value written to ETS ctrl (0x0000) after reset.
- `ALERT_CFG_INIT`, 32'h0000_000F: value written to ETS alert config (0x000C) after reset.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `svc_enable` in 1: enables alert servicing.
- `alert_interrupt` in 1: alert level from the ETS monitor.
- `reg_wr_en` out 1: register write strobe to the monitor.
- `reg_addr` out 16: register address to the monitor.
- `reg_wr_data` out 32: write data.
- `reg_rd_data` in 32: combinational read data for the current `reg_addr`.
- `rec_valid` out 1: FIFO not empty.
- `rec_ready` in 1: consumer accepts the head record.
- `rec_pc` out 32: head record, last anomaly PC.
- `rec_delta` out 32: head record, timing delta.
- `rec_count` out 32: head record, anomaly count.
- `busy` out 1: state is not IDLE.
- `drop_count` out 16: records lost to a full FIFO (saturating).
- `coalesce_count` out 16: alert edges merged into an already-pending service (saturating).

## Operation
- States: INIT_CTRL, INIT_CFG, IDLE, RD_PC, RD_DELTA, RD_COUNT.
- Reset enters INIT_CTRL.
- INIT_CTRL: drives `reg_wr_en`=1, `reg_addr`=0x0000, `reg_wr_data`=CTRL_INIT for one cycle, then goes to INIT_CFG.
- INIT_CFG: drives `reg_wr_en`=1, `reg_addr`=0x000C, `reg_wr_data`=ALERT_CFG_INIT for one cycle, then goes to IDLE.
- The init writes ignore `svc_enable`.
- Edge detect: `alert_q` is registered `alert_interrupt`; rise = `alert_interrupt` & ~`alert_q`. Rises are counted only while `svc_enable`=1.
- `pending` flag:
  - A rise in any state other than IDLE sets `pending`.
  - If `pending` is already set, the rise increments `coalesce_count` instead.
  - A rise in IDLE with `pending` set also increments `coalesce_count`.
- IDLE: if `svc_enable` and (rise or `pending`), go to RD_PC and clear `pending`.
- RD_PC: `reg_addr`=0x0014; capture `reg_rd_data` into the PC holding register.
- RD_DELTA: `reg_addr`=0x0018; capture into the delta holding register.
- RD_COUNT: `reg_addr`=0x001C; the {pc, delta, `reg_rd_data`} record is pushed at the end of this cycle, then the block returns to IDLE.
- Push rules:
  - If the FIFO is full at that edge, the record is dropped and `drop_count` increments. A same-cycle pop does not free space for the push.
  - `drop_count` and `coalesce_count` saturate at 0xFFFF.
- Pop on `rec_valid` & `rec_ready`. Read/write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- Deasserting `svc_enable` mid-service: the current service completes; `pending` is retained but is not acted on until `svc_enable` returns high.
- Bus idle value: `reg_wr_en`=0, `reg_addr`=0x0000, `reg_wr_data`=0. Reads from a non-read state have no side effects.

## Timing
- Reset values:
  - State INIT_CTRL.
  - `reg_wr_en`=1, `reg_addr`=0x0000, `reg_wr_data`=CTRL_INIT. All bus outputs decode combinationally from state.
  - `rec_valid`=0, `rec_*`=0 when empty, `busy`=1.
  - Both counters 0; `pending`=0; `alert_q`=0.
- Init occupies cycles 0–1 after reset release. IDLE is reached at the 2nd edge.
- Service latency: a rise sampled at edge E0 in IDLE gives RD_PC in E0–E1, RD_DELTA in E1–E2, RD_COUNT in E2–E3. `rec_valid`=1 after E3 if the FIFO was empty.
- Back-to-back: a pending service starts at the edge after the return to IDLE. Minimum spacing is 4 cycles per record.
- `rec_*` hold the FIFO head. They change only on a pop, or on a push into an empty FIFO.
- Asserting reset mid-service aborts the service, clears the FIFO, and restarts INIT.

## Test plan
- Reset release → `reg_wr_en` high with addr 0x0000/data 0x1, then addr 0x000C/data 0xF; `busy` low from cycle 2.
- Single alert rise with monitor returning PC=0x8000_0100, delta=0x25, count=7 → after 3 cycles a record {0x80000100, 0x25, 7} appears and `rec_valid`=1.
- Two rises 2 cycles apart, then a third during the same service → two records emitted; `coalesce_count`=1.
- `rec_ready`=0, 5 alerts with DEPTH=4 → 4 records held, `drop_count`=1; draining returns the records in order.
- `svc_enable`=0 with an alert rise → no reads, `pending`=0; enable later → still no record.
- Reset asserted during RD_DELTA with 2 records queued → `rec_valid`=0, counters 0, init writes repeat.

Source files
------------

// File: rtl/ets_alert_servicer.sv
// ets_alert_servicer
// Register-bus initiator for the ETS monitor. After reset it programs the
// monitor's control and alert-config registers. On every rising edge of
// alert_interrupt it reads the last-anomaly PC, the timing delta and the
// anomaly count. It then queues them as one record in a small FIFO for a
// downstream logger.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   svc_enable            : enables alert servicing (init writes ignore it)
//   alert_interrupt       : alert level from the monitor
//   reg_wr_en/addr/wr_data: register bus towards the monitor (decoded from state)
//   reg_rd_data           : combinational read data for the current reg_addr
//   rec_valid/rec_ready   : record stream handshake
//   rec_pc/delta/count    : head record (zero while the FIFO is empty)
//   busy                  : FSM is not in IDLE
//   drop_count            : records lost to a full FIFO (saturating)
//   coalesce_count        : alert edges merged into a pending service (saturating)
//   dbg_state             : current FSM state, for observation
//
// Handshake: a record transfers on every rising clk edge where rec_valid and
// rec_ready are both high; rec_valid never depends on rec_ready, and the
// head record is held stable until it is transferred.
module ets_alert_servicer #(
   parameter int          DEPTH          = 4,
   parameter logic [31:0] CTRL_INIT      = 32'h0000_0001,
   parameter logic [31:0] ALERT_CFG_INIT = 32'h0000_000F
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        svc_enable,
   input  logic        alert_interrupt,
   output logic        reg_wr_en,
   output logic [15:0] reg_addr,
   output logic [31:0] reg_wr_data,
   input  logic [31:0] reg_rd_data,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [31:0] rec_pc,
   output logic [31:0] rec_delta,
   output logic [31:0] rec_count,
   output logic        busy,
   output logic [15:0] drop_count,
   output logic [15:0] coalesce_count,
   output logic [2:0]  dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      INIT_CTRL = 3'd0,
      INIT_CFG  = 3'd1,
      IDLE      = 3'd2,
      RD_PC     = 3'd3,
      RD_DELTA  = 3'd4,
      RD_COUNT  = 3'd5
   } state_e;

   state_e       state_q;
   logic         alert_q;
   logic         pending_q;
   logic [31:0]  pc_q;
   logic [31:0]  delta_q;
   logic [15:0]  drop_q;
   logic [15:0]  coal_q;
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;
   logic [95:0]  mem_q [DEPTH];

   logic rise;
   logic empty;
   logic full;
   logic push;
   logic drop;
   logic pop;

   // Edges only count while servicing is enabled.
   assign rise  = alert_interrupt & ~alert_q & svc_enable;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // Fullness is judged before any same-cycle pop, so a pop never makes room.
   assign push  = (state_q == RD_COUNT) && !full;
   assign drop  = (state_q == RD_COUNT) && full;
   assign pop   = rec_valid && rec_ready;

   // Bus outputs decode combinationally from state.
   always_comb begin
      reg_wr_en   = 1'b0;
      reg_addr    = 16'h0000;
      reg_wr_data = 32'h0000_0000;
      case (state_q)
         INIT_CTRL: begin
            reg_wr_en   = 1'b1;
            reg_wr_data = CTRL_INIT;
         end
         INIT_CFG: begin
            reg_wr_en   = 1'b1;
            reg_addr    = 16'h000C;
            reg_wr_data = ALERT_CFG_INIT;
         end
         RD_PC:    reg_addr = 16'h0014;
         RD_DELTA: reg_addr = 16'h0018;
         RD_COUNT: reg_addr = 16'h001C;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= INIT_CTRL;
         alert_q   <= 1'b0;
         pending_q <= 1'b0;
         pc_q      <= 32'h0;
         delta_q   <= 32'h0;
         drop_q    <= 16'h0;
         coal_q    <= 16'h0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         alert_q <= alert_interrupt;

         // An edge arriving while a service is already owed is merged into it.
         if (rise && pending_q) begin
            if (coal_q != 16'hFFFF) coal_q <= coal_q + 16'd1;
         end else if (rise && state_q != IDLE) begin
            pending_q <= 1'b1;
         end

         case (state_q)
            INIT_CTRL: state_q <= INIT_CFG;
            INIT_CFG:  state_q <= IDLE;
            IDLE: begin
               // pending_q is kept while disabled and acted on once re-enabled.
               if (svc_enable && (rise || pending_q)) begin
                  state_q   <= RD_PC;
                  pending_q <= 1'b0;
               end
            end
            RD_PC: begin
               pc_q    <= reg_rd_data;
               state_q <= RD_DELTA;
            end
            RD_DELTA: begin
               delta_q <= reg_rd_data;
               state_q <= RD_COUNT;
            end
            RD_COUNT: state_q <= IDLE;
            default:  state_q <= INIT_CTRL;
         endcase

         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {pc_q, delta_q, reg_rd_data};
   end

   assign rec_valid      = !empty;
   assign rec_pc         = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]][95:64];
   assign rec_delta      = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]][63:32];
   assign rec_count      = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]][31:0];
   assign busy           = (state_q != IDLE);
   assign drop_count     = drop_q;
   assign coalesce_count = coal_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_ets_alert_servicer.sv
// Self-checking bench for ets_alert_servicer. Directed scenarios push the
// records they expect into exp_q; a monitor pops and compares each record
// as it transfers on the rec_* stream.
module tb_ets_alert_servicer;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst_n;
   logic        svc_enable;
   logic        alert_interrupt;
   logic        reg_wr_en;
   logic [15:0] reg_addr;
   logic [31:0] reg_wr_data;
   logic [31:0] reg_rd_data;
   logic        rec_valid;
   logic        rec_ready;
   logic [31:0] rec_pc;
   logic [31:0] rec_delta;
   logic [31:0] rec_count;
   logic        busy;
   logic [15:0] drop_count;
   logic [15:0] coalesce_count;
   logic [2:0]  dbg_state;

   // Register contents the fake monitor returns.
   logic [31:0] m_pc;
   logic [31:0] m_delta;
   logic [31:0] m_count;

   int n_checks = 0;
   int n_errors = 0;
   logic [95:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ets_alert_servicer #(
      .DEPTH(4),
      .CTRL_INIT(32'h0000_0001),
      .ALERT_CFG_INIT(32'h0000_000F)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .svc_enable(svc_enable),
      .alert_interrupt(alert_interrupt),
      .reg_wr_en(reg_wr_en),
      .reg_addr(reg_addr),
      .reg_wr_data(reg_wr_data),
      .reg_rd_data(reg_rd_data),
      .rec_valid(rec_valid),
      .rec_ready(rec_ready),
      .rec_pc(rec_pc),
      .rec_delta(rec_delta),
      .rec_count(rec_count),
      .busy(busy),
      .drop_count(drop_count),
      .coalesce_count(coalesce_count),
      .dbg_state(dbg_state)
   );

   // Monitor register file model: combinational read by address.
   always_comb begin
      reg_rd_data = 32'h0;
      case (reg_addr)
         16'h0014: reg_rd_data = m_pc;
         16'h0018: reg_rd_data = m_delta;
         16'h001C: reg_rd_data = m_count;
         default:  reg_rd_data = 32'h0;
      endcase
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_mon(input logic [31:0] pc, input logic [31:0] dl, input logic [31:0] ct);
      m_pc    = pc;
      m_delta = dl;
      m_count = ct;
   endtask

   // One isolated alert: rise sampled at E0, record pushed at E3.
   task automatic one_alert();
      alert_interrupt = 1'b1;
      step(1);
      alert_interrupt = 1'b0;
      step(3);
   endtask

   task automatic drain(input int n);
      rec_ready = 1'b1;
      step(n);
      rec_ready = 1'b0;
   endtask

   task automatic check_init_writes(input string tag);
      check({tag, " ctrl we"},   {95'd0, reg_wr_en}, 96'd1);
      check({tag, " ctrl addr"}, {80'd0, reg_addr}, 96'h0);
      check({tag, " ctrl data"}, {64'd0, reg_wr_data}, 96'h1);
      check({tag, " busy0"},     {95'd0, busy}, 96'd1);
      step(1);
      check({tag, " cfg we"},    {95'd0, reg_wr_en}, 96'd1);
      check({tag, " cfg addr"},  {80'd0, reg_addr}, 96'hC);
      check({tag, " cfg data"},  {64'd0, reg_wr_data}, 96'hF);
      step(1);
      check({tag, " idle we"},   {95'd0, reg_wr_en}, 96'd0);
      check({tag, " busy2"},     {95'd0, busy}, 96'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL record unexpected: got %0h expected none", {rec_pc, rec_delta, rec_count});
         end else begin
            check("record", {rec_pc, rec_delta, rec_count}, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      svc_enable = 1'b0;
      alert_interrupt = 1'b0;
      rec_ready = 1'b0;
      set_mon(32'h0, 32'h0, 32'h0);
      step(3);

      // Reset state
      check("rst rec_valid", {95'd0, rec_valid}, 96'd0);
      check("rst rec_pc",    {64'd0, rec_pc}, 96'd0);
      check("rst drop",      {80'd0, drop_count}, 96'd0);
      check("rst coal",      {80'd0, coalesce_count}, 96'd0);

      // Init writes after release
      rst_n = 1'b1;
      check_init_writes("init");

      // Single alert
      svc_enable = 1'b1;
      set_mon(32'h8000_0100, 32'h25, 32'h7);
      exp_q.push_back({32'h8000_0100, 32'h25, 32'h7});
      alert_interrupt = 1'b1;
      step(1);
      alert_interrupt = 1'b0;
      check("single rd_pc addr", {80'd0, reg_addr}, 96'h14);
      check("single busy",       {95'd0, busy}, 96'd1);
      step(1);
      check("single rd_delta addr", {80'd0, reg_addr}, 96'h18);
      step(1);
      check("single rd_count addr", {80'd0, reg_addr}, 96'h1C);
      check("single valid early",   {95'd0, rec_valid}, 96'd0);
      step(1);
      check("single valid",  {95'd0, rec_valid}, 96'd1);
      check("single idle",   {95'd0, busy}, 96'd0);
      drain(1);
      check("single empty after pop", {95'd0, rec_valid}, 96'd0);

      // Two rises 2 cycles apart plus a third merged into the owed service
      set_mon(32'hA000_0000, 32'h11, 32'h21);
      exp_q.push_back({32'hA000_0000, 32'h11, 32'h21});
      alert_interrupt = 1'b1;
      step(1);                 // E0: service starts
      alert_interrupt = 1'b0;
      step(1);                 // E1
      alert_interrupt = 1'b1;
      step(1);                 // E2: rise in RD_DELTA -> pending
      alert_interrupt = 1'b0;
      step(1);                 // E3: first record pushed
      set_mon(32'hB000_0004, 32'h12, 32'h22);
      exp_q.push_back({32'hB000_0004, 32'h12, 32'h22});
      alert_interrupt = 1'b1;
      step(1);                 // E4: rise in IDLE with pending -> merged
      alert_interrupt = 1'b0;
      check("coal started", {95'd0, busy}, 96'd1);
      step(3);
      check("coal count", {80'd0, coalesce_count}, 96'd1);
      check("coal idle",  {95'd0, busy}, 96'd0);
      step(2);
      check("coal no third", {95'd0, busy}, 96'd0);
      drain(2);
      check("coal drained", {95'd0, rec_valid}, 96'd0);

      // Overflow: 5 alerts into a 4-deep FIFO with the consumer stalled
      for (int i = 0; i < 5; i++) begin
         set_mon(32'h1000 + 32'(i), 32'h200 + 32'(i), 32'(i + 1));
         if (i < 4) exp_q.push_back({32'h1000 + 32'(i), 32'h200 + 32'(i), 32'(i + 1)});
         one_alert();
      end
      check("full drop", {80'd0, drop_count}, 96'd1);
      check("full valid", {95'd0, rec_valid}, 96'd1);
      check("full head pc", {64'd0, rec_pc}, 96'h1000);
      drain(4);
      check("full drained", {95'd0, rec_valid}, 96'd0);

      // Disabled: a rise is ignored and not remembered
      svc_enable = 1'b0;
      set_mon(32'hDEAD_0000, 32'h1, 32'h1);
      alert_interrupt = 1'b1;
      step(1);
      check("dis busy", {95'd0, busy}, 96'd0);
      check("dis addr", {80'd0, reg_addr}, 96'h0);
      step(2);
      alert_interrupt = 1'b0;
      svc_enable = 1'b1;
      step(4);
      check("dis no service", {95'd0, busy}, 96'd0);
      check("dis no record",  {95'd0, rec_valid}, 96'd0);

      // Reset during RD_DELTA with two records queued
      set_mon(32'h5, 32'h6, 32'h7);
      one_alert();
      one_alert();
      check("pre-rst valid", {95'd0, rec_valid}, 96'd1);
      alert_interrupt = 1'b1;
      step(1);
      alert_interrupt = 1'b0;
      step(1);
      check("pre-rst rd_delta", {80'd0, reg_addr}, 96'h18);
      rst_n = 1'b0;
      #1;
      check("mid-rst valid", {95'd0, rec_valid}, 96'd0);
      check("mid-rst drop",  {80'd0, drop_count}, 96'd0);
      check("mid-rst coal",  {80'd0, coalesce_count}, 96'd0);
      check("mid-rst rec_count", {64'd0, rec_count}, 96'd0);
      step(2);
      rst_n = 1'b1;
      check_init_writes("reinit");
      check("reinit empty", {95'd0, rec_valid}, 96'd0);

      check("scoreboard leftover", 96'(exp_q.size()), 96'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
